// File: rtl/add_seq_arbiter_pkg.sv
// Shared types and constants for the sequential slice-adder arbiter.
package add_seq_pkg;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction
endpackage

// File: rtl/add_seq_arbiter_if.sv
// Request/result bundle between NUM_REQ requesters and the shared slice adder.
interface add_seq_arbiter_if
  import add_seq_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_sub;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-1:0]         res_sum;
  logic                      res_cout;
  logic [ID_W-1:0]           res_id;
  logic                      busy;

  modport master (
    output req_valid, req_a, req_b, req_sub, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_id, busy
  );
endinterface

// File: rtl/add_rr_arbiter.sv
// Stateless round-robin picker: first set req at or above ptr, wrapping; gnt is one-hot or zero.
module add_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (en && !found && req[i] && (i == (int'(ptr) + off) % NUM_REQ)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/add_seq_arbiter.sv
// Shares one SLICE_W adder among NUM_REQ requesters; 64-bit result 64/SLICE_W cycles after accept,
// held in DONE until res_ready, no accepts while busy. Define ADD_SEQ_SUB_EN to honour req_sub.
module add_seq_arbiter
  import add_seq_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SLICE_W = 16
) (
  input logic              clk,
  input logic              rst,
  add_seq_arbiter_if.slave bus
);
  localparam int ID_W = id_width(NUM_REQ);
  localparam int NS   = DATA_W / SLICE_W;
  localparam int K_W  = (NS > 1) ? $clog2(NS) : 1;

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   gnt;
  logic                 arb_en, accept, last_slice, carry_init, carry;
  logic [ID_W-1:0]      win, ptr, ptr_nxt, id_q;
  logic [K_W-1:0]       k;
  logic [DATA_W-1:0]    a_q, b_q, res_q;
  logic [SLICE_W-1:0]   a_sl, b_raw, b_sl;
  logic [SLICE_W:0]     sl_sum;

  // Arbitration is only live in IDLE, so req_ready is naturally zero in RUN/DONE and in reset.
  assign arb_en = (state == ST_IDLE) && !rst;

  add_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign accept     = |gnt;
  assign last_slice = (k == K_W'(NS - 1));
  assign ptr_nxt    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) win = ID_W'(i);
  end

  assign a_sl  = a_q[int'(k)*SLICE_W +: SLICE_W];
  assign b_raw = b_q[int'(k)*SLICE_W +: SLICE_W];

`ifdef ADD_SEQ_SUB_EN
  logic sub_q;

  // Subtraction is A + ~B + 1: the +1 enters through the carry register at accept.
  assign b_sl       = sub_q ? ~b_raw : b_raw;
  assign carry_init = bus.req_sub[win];

  always_ff @(posedge clk) begin
    if (rst)         sub_q <= 1'b0;
    else if (accept) sub_q <= bus.req_sub[win];
  end
`else
  logic unused_sub;

  assign unused_sub = ^bus.req_sub;
  assign b_sl       = b_raw;
  assign carry_init = 1'b0;
`endif

  assign sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)        state_nxt = ST_RUN;
      ST_RUN:  if (last_slice)    state_nxt = ST_DONE;
      ST_DONE: if (bus.res_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = gnt;
    bus.res_valid = (state == ST_DONE) && !rst;
    bus.busy      = (state != ST_IDLE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      k     <= '0;
      carry <= 1'b0;
      res_q <= '0;
      id_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      a_q   <= bus.req_a[int'(win)*DATA_W +: DATA_W];
      b_q   <= bus.req_b[int'(win)*DATA_W +: DATA_W];
      id_q  <= win;
      k     <= '0;
      carry <= carry_init;
      ptr   <= ptr_nxt;
    end else if (state == ST_RUN) begin
      res_q[int'(k)*SLICE_W +: SLICE_W] <= sl_sum[SLICE_W-1:0];
      carry <= sl_sum[SLICE_W];
      k     <= k + 1'b1;
    end
  end

  assign bus.res_sum  = res_q;
  assign bus.res_cout = carry;
  assign bus.res_id   = id_q;
endmodule

// File: tb/tb_add_seq_arbiter.sv
// Bench for add_seq_arbiter: directed table, hand sequences, and a random run against a rule-level model.
module tb_add_seq_arbiter;
  import add_seq_pkg::*;

  localparam int NR = 2;
  localparam int NS = 4;
`ifdef ADD_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_seq_arbiter_if #(.NUM_REQ(NR)) bus   ();
  add_seq_arbiter_if #(.NUM_REQ(NR)) bus8  ();
  add_seq_arbiter_if #(.NUM_REQ(NR)) bus32 ();

  add_seq_arbiter #(.NUM_REQ(NR), .SLICE_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
  add_seq_arbiter #(.NUM_REQ(NR), .SLICE_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  add_seq_arbiter #(.NUM_REQ(NR), .SLICE_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] es;
    logic        ec;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain 64-bit modulo add/sub; carry means the add wrapped, or no borrow.
  function automatic logic [64:0] ref_op(input logic [63:0] a, input logic [63:0] b, input logic sub);
    logic [63:0] s;
    logic        c;
    if (sub && SUB_EN) begin
      s = a - b;
      c = (a >= b);
    end else begin
      s = a + b;
      c = (s < a);
    end
    return {c, s};
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int off = 0; off < NR; off++)
      if (v[(p + off) % NR]) return (p + off) % NR;
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_sub = '0; bus.res_ready = 1'b0;
    bus8.req_valid = '0; bus8.req_a = '0; bus8.req_b = '0; bus8.req_sub = '0; bus8.res_ready = 1'b0;
    bus32.req_valid = '0; bus32.req_a = '0; bus32.req_b = '0; bus32.req_sub = '0; bus32.res_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One operation on an idle DUT; operands are scribbled right after accept to prove capture.
  task automatic do_op(input int id, input logic [63:0] a, input logic [63:0] b, input logic sub,
                       output logic [NR-1:0] rdy, output logic [63:0] s, output logic c,
                       output int rid, output int lat);
    @(negedge clk);
    bus.req_a[id*64 +: 64] = a;
    bus.req_b[id*64 +: 64] = b;
    bus.req_sub[id]        = sub;
    bus.req_valid[id]      = 1'b1;
    #1 rdy = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.req_a     = ~bus.req_a;
    bus.req_b     = ~bus.req_b;
    bus.req_sub   = ~bus.req_sub;
    lat = 0;
    while (!bus.res_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    s   = bus.res_sum;
    c   = bus.res_cout;
    rid = int'(bus.res_id);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] rdy;
    logic [63:0]   s;
    logic          c;
    int            rid, lat;

    tbl[0] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1};
    tbl[1] = '{0, 64'd5, 64'd7, 1'b1, SUB_EN ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd12, 1'b0};
    tbl[2] = '{1, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0001_0000_0000_0000, 1'b0};
    tbl[3] = '{1, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0};
    tbl[4] = '{0, 64'd7, 64'd5, 1'b1, SUB_EN ? 64'd2 : 64'd12, SUB_EN};
    tbl[5] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};
    tbl[6] = '{0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0};
    tbl[7] = '{1, 64'd5, 64'd5, 1'b1, SUB_EN ? 64'd0 : 64'd10, SUB_EN};

    // Reset behaviour, with requests already pending.
    clear_inputs();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    @(negedge clk); #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    #1;
    check("rst_res_sum", bus.res_sum, 0);
    check("rst_res_cout", bus.res_cout, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_busy_after", bus.busy, 0);

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sub, rdy, s, c, rid, lat);
      check($sformatf("tbl%0d_ready", i), rdy, 64'd1 << tbl[i].id);
      check($sformatf("tbl%0d_latency", i), lat, NS);
      check($sformatf("tbl%0d_sum", i), s, tbl[i].es);
      check($sformatf("tbl%0d_cout", i), c, tbl[i].ec);
      check($sformatf("tbl%0d_id", i), rid, tbl[i].id);
    end

    // Carry chain across every slice width.
    begin
      int l8, l32;
      logic [63:0] s8, s32;
      @(negedge clk);
      bus8.req_a[63:0] = 64'h0000_FFFF_FFFF_FFFF;  bus8.req_b[63:0] = 64'd1;  bus8.req_valid = 2'b01;
      bus32.req_a[63:0] = 64'h0000_FFFF_FFFF_FFFF; bus32.req_b[63:0] = 64'd1; bus32.req_valid = 2'b01;
      @(posedge clk); #1;
      bus8.req_valid = '0; bus32.req_valid = '0;
      l8 = -1; l32 = -1; s8 = '0; s32 = '0;
      for (int cyc = 0; cyc <= 20; cyc++) begin
        if (l8 < 0 && bus8.res_valid) begin l8 = cyc; s8 = bus8.res_sum; end
        if (l32 < 0 && bus32.res_valid) begin l32 = cyc; s32 = bus32.res_sum; end
        if (l8 >= 0 && l32 >= 0) break;
        @(posedge clk); #1;
      end
      check("chain8_latency", l8, 8);
      check("chain8_sum", s8, 64'h0001_0000_0000_0000);
      check("chain32_latency", l32, 2);
      check("chain32_sum", s32, 64'h0001_0000_0000_0000);
      bus8.res_ready = 1'b1; bus32.res_ready = 1'b1;
      @(posedge clk); #1;
      bus8.res_ready = 1'b0; bus32.res_ready = 1'b0;
      check("chain8_released", bus8.busy, 0);
      check("chain32_released", bus32.busy, 0);
    end

    // Fairness: both requesters valid forever, consumer always ready.
    begin
      int cyc_q[$];
      int id_q[$];
      logic [63:0] sum_q[$];
      do_reset();
      bus.req_a = {64'd200, 64'd100};
      bus.req_b = {64'd2, 64'd1};
      bus.req_valid = 2'b11;
      bus.res_ready = 1'b1;
      for (int cyc = 0; cyc < 45; cyc++) begin
        #1;
        if (bus.res_valid && id_q.size() < 4) begin
          cyc_q.push_back(cyc);
          id_q.push_back(int'(bus.res_id));
          sum_q.push_back(bus.res_sum);
        end
        @(negedge clk);
      end
      check("fair_count", id_q.size(), 4);
      for (int i = 0; i < id_q.size(); i++) begin
        check($sformatf("fair_id%0d", i), id_q[i], i % 2);
        check($sformatf("fair_sum%0d", i), sum_q[i], (i % 2) ? 64'd202 : 64'd101);
        if (i > 0) check($sformatf("fair_gap%0d", i), cyc_q[i] - cyc_q[i-1], 6);
      end
      clear_inputs();
      repeat (8) @(posedge clk);
    end

    // Backpressure: result held for 10 cycles while another requester waits.
    begin
      int bad_vld, bad_sum, bad_rdy, extra;
      logic [63:0] held;
      do_reset();
      bus.req_a[63:0] = 64'd3; bus.req_b[63:0] = 64'd4; bus.req_valid = 2'b01;
      @(posedge clk); #1;
      bus.req_valid = '0;
      for (int cyc = 0; cyc < 30 && !bus.res_valid; cyc++) begin
        @(posedge clk); #1;
      end
      held = bus.res_sum;
      check("bp_first_sum", held, 64'd7);
      @(negedge clk);
      bus.req_a[127:64] = 64'd9; bus.req_b[127:64] = 64'd9; bus.req_valid = 2'b10;
      bad_vld = 0; bad_sum = 0; bad_rdy = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
        #1;
        if (bus.res_valid !== 1'b1) bad_vld++;
        if (bus.res_sum !== 64'd7) bad_sum++;
        if (bus.req_ready !== '0) bad_rdy++;
        @(negedge clk);
      end
      check("bp_valid_held", bad_vld, 0);
      check("bp_sum_stable", bad_sum, 0);
      check("bp_ready_zero", bad_rdy, 0);
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      extra = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
        if (bus.res_valid) extra++;
        @(posedge clk); #1;
      end
      check("bp_single_result", extra, 0);
    end

    // Reset in the middle of RUN.
    begin
      do_reset();
      do_op(0, 64'd1, 64'd1, 1'b0, rdy, s, c, rid, lat);
      check("abort_pre_sum", s, 64'd2);
      @(negedge clk);
      bus.req_a[63:0] = 64'd50; bus.req_b[63:0] = 64'd60; bus.req_valid = 2'b01;
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      bus.req_valid = 2'b11;
      @(negedge clk); #1;
      check("abort_rst_ready", bus.req_ready, 0);
      check("abort_rst_busy", bus.busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.req_valid = '0;
      check("abort_busy", bus.busy, 0);
      check("abort_res_valid", bus.res_valid, 0);
      check("abort_res_sum", bus.res_sum, 0);
      @(negedge clk);
      bus.req_a = {64'd11, 64'd20}; bus.req_b = {64'd11, 64'd22};
      bus.req_valid = 2'b11;
      #1 check("abort_ptr_zero", bus.req_ready, 2'b01);
      @(posedge clk); #1;
      bus.req_valid = '0;
      for (int cyc = 0; cyc < 30 && !bus.res_valid; cyc++) begin
        @(posedge clk); #1;
      end
      check("abort_new_valid", bus.res_valid, 1);
      check("abort_new_sum", bus.res_sum, 64'd42);
      check("abort_new_id", bus.res_id, 0);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
    end

    // Random traffic against the rule-level model.
    begin
      int          m_ptr, m_age, w, n_res, drop;
      bit          m_busy, exp_vld, hs;
      logic [64:0] m_exp;
      int          m_id;
      logic [NR-1:0] exp_rdy;
      do_reset();
      m_ptr = 0; m_age = 0; m_busy = 1'b0; n_res = 0; drop = -1; m_exp = '0; m_id = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        if (drop >= 0) bus.req_valid[drop] = 1'b0;
        drop = -1;
        for (int i = 0; i < NR; i++) begin
          if (!bus.req_valid[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              bus.req_a[i*64 +: 64] = {$urandom, $urandom};
              bus.req_b[i*64 +: 64] = ($urandom_range(0, 3) == 0) ? ~bus.req_a[i*64 +: 64] : {$urandom, $urandom};
              bus.req_sub[i]        = 1'($urandom_range(0, 1));
              bus.req_valid[i]      = 1'b1;
            end
          end else if ($urandom_range(0, 9) == 0) begin
            bus.req_valid[i] = 1'b0;
          end
        end
        bus.res_ready = ($urandom_range(0, 3) != 0);
        #1;
        exp_rdy = '0;
        w = m_busy ? -1 : rr_pick(bus.req_valid, m_ptr);
        if (w >= 0) exp_rdy[w] = 1'b1;
        exp_vld = m_busy && (m_age >= NS);
        check("rnd_ready", bus.req_ready, exp_rdy);
        check("rnd_valid", bus.res_valid, exp_vld);
        if (exp_vld) begin
          check("rnd_sum", bus.res_sum, m_exp[63:0]);
          check("rnd_cout", bus.res_cout, m_exp[64]);
          check("rnd_id", bus.res_id, m_id);
        end
        hs = exp_vld && bus.res_ready;
        if (w >= 0) begin
          m_exp = ref_op(bus.req_a[w*64 +: 64], bus.req_b[w*64 +: 64], bus.req_sub[w]);
          m_id  = w;
        end
        @(posedge clk);
        if (hs) begin
          m_busy = 1'b0;
          n_res++;
        end else if (w >= 0) begin
          m_busy = 1'b1;
          m_age  = 0;
          m_ptr  = (w + 1) % NR;
          drop   = w;
        end else if (m_busy) begin
          m_age++;
        end
      end
      check("rnd_results_seen", (n_res > 20), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
